// File: rtl/adder_accum_nbit.sv
// adder_accum_nbit: registered add/sub/accumulate/load unit with ready/valid handshake and sticky flags
module adder_accum_nbit #(
  parameter int N = 10,
  parameter int GUARD = 4,
  parameter int SAT = 0
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [N-1:0]         a,
  input  logic [N-1:0]         b,
  input  logic [1:0]           mode,
  input  logic                 clr_flags,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [N+GUARD-1:0]   result,
  output logic [N+GUARD-1:0]   acc,
  output logic                 ovf,
  output logic                 brw
);
  localparam int ACC_W = N + GUARD;
  logic             accept, consume, set_ovf, set_brw;
  logic [N:0]       sum;
  logic [ACC_W-1:0] a_ext, b_ext, diff, acc_new, res_new;
  logic [ACC_W:0]   t;
  always_comb begin
    in_ready = !out_valid || out_ready;
    accept = in_valid && in_ready;
    consume = out_valid && out_ready;
    a_ext = ACC_W'(a);
    b_ext = ACC_W'(b);
    sum = {1'b0, a} + {1'b0, b};
    diff = a_ext - b_ext;
    t = {1'b0, acc} + {1'b0, a_ext};
    acc_new = (t[ACC_W] && SAT != 0) ? '1 : t[ACC_W-1:0];
    res_new = mode == 2'd0 ? ACC_W'(sum) : mode == 2'd1 ? diff : mode == 2'd2 ? acc_new : a_ext;
    set_ovf = accept && mode == 2'd2 && t[ACC_W];
    set_brw = accept && mode == 2'd1 && a < b;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      result <= '0;
      acc <= '0;
      ovf <= 1'b0;
      brw <= 1'b0;
    end else begin
      out_valid <= accept ? 1'b1 : consume ? 1'b0 : out_valid;
      if (accept) result <= res_new;
      if (accept && mode == 2'd2) acc <= acc_new;
      if (accept && mode == 2'd3) acc <= a_ext;
      ovf <= set_ovf ? 1'b1 : clr_flags ? 1'b0 : ovf;
      brw <= set_brw ? 1'b1 : clr_flags ? 1'b0 : brw;
    end
  end
endmodule

// File: tb/tb_adder_accum_nbit.sv
// tb_adder_accum_nbit: directed checks of wrap and saturating instances sharing one stimulus stream
module tb_adder_accum_nbit;
  logic        clk = 0, rst_n = 0, in_valid = 0, clr_flags = 0, out_ready = 1;
  logic [9:0]  a = 0, b = 0;
  logic [1:0]  mode = 0;
  logic        in_ready, out_valid, ovf, brw;
  logic        s_in_ready, s_out_valid, s_ovf, s_brw;
  logic [13:0] result, acc, s_result, s_acc;
  int n_tests = 0, n_fail = 0;

  always #5 clk = ~clk;

  adder_accum_nbit #(.N(10), .GUARD(4), .SAT(0)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .a(a), .b(b),
    .mode(mode), .clr_flags(clr_flags), .out_valid(out_valid), .out_ready(out_ready),
    .result(result), .acc(acc), .ovf(ovf), .brw(brw));

  adder_accum_nbit #(.N(10), .GUARD(4), .SAT(1)) dut_sat (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(s_in_ready), .a(a), .b(b),
    .mode(mode), .clr_flags(clr_flags), .out_valid(s_out_valid), .out_ready(out_ready),
    .result(s_result), .acc(s_acc), .ovf(s_ovf), .brw(s_brw));

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic do_op(input logic [1:0] m, input logic [9:0] x, input logic [9:0] y);
    in_valid = 1; mode = m; a = x; b = y;
    @(posedge clk); #1;
    in_valid = 0;
  endtask

  task automatic idle();
    @(posedge clk); #1;
  endtask

  initial begin
    for (int i = 0; i < 3; i++) begin
      in_valid = 1; a = 10'($urandom); b = 10'($urandom); mode = 2'($urandom);
      clr_flags = 1'($urandom); out_ready = 1'($urandom);
      idle();
      chk("rst_out_valid", out_valid, 0);
      chk("rst_result", result, 0);
      chk("rst_acc", acc, 0);
      chk("rst_flags", {ovf, brw, s_ovf, s_brw}, 0);
      chk("rst_in_ready", in_ready, 1);
    end
    in_valid = 0; clr_flags = 0; out_ready = 1;
    @(negedge clk); rst_n = 1;
    idle();
    chk("post_rst_out_valid", out_valid, 0);

    do_op(2'd0, 10'd1023, 10'd1023);
    chk("add_max_result", result, 2046);
    chk("add_max_valid", out_valid, 1);
    chk("add_max_acc", acc, 0);
    chk("add_max_ovf", ovf, 0);
    do_op(2'd0, 10'd10, 10'd500);
    chk("add_b2b_result", result, 510);
    chk("add_b2b_valid", out_valid, 1);
    idle();
    chk("drain_valid", out_valid, 0);

    do_op(2'd1, 10'd300, 10'd150);
    chk("sub_result", result, 150);
    chk("sub_brw0", brw, 0);
    do_op(2'd1, 10'd5, 10'd10);
    chk("sub_neg_result", result, 16379);
    chk("sub_brw1", brw, 1);
    idle();
    chk("brw_sticky", brw, 1);
    clr_flags = 1; idle(); clr_flags = 0;
    chk("brw_cleared", brw, 0);
    clr_flags = 1; do_op(2'd1, 10'd5, 10'd10); clr_flags = 0;
    chk("brw_set_wins", brw, 1);
    clr_flags = 1; idle(); clr_flags = 0;
    chk("brw_cleared2", brw, 0);

    do_op(2'd3, 10'd1000, 10'd77);
    chk("load_result", result, 1000);
    chk("load_acc", acc, 1000);
    chk("load_acc_sat", s_acc, 1000);
    for (int k = 1; k <= 16; k++) begin
      do_op(2'd2, 10'd1023, 10'd0);
      if (k == 15) begin
        chk("acc15", acc, 16345);
        chk("acc15_ovf", ovf, 0);
        chk("acc15_sat_ovf", s_ovf, 0);
      end
    end
    chk("acc16_wrap", acc, 984);
    chk("acc16_wrap_result", result, 984);
    chk("acc16_ovf", ovf, 1);
    chk("acc16_sat", s_acc, 16383);
    chk("acc16_sat_result", s_result, 16383);
    chk("acc16_sat_ovf", s_ovf, 1);
    do_op(2'd2, 10'd1, 10'd0);
    chk("acc17_wrap", acc, 985);
    chk("acc17_sat", s_acc, 16383);
    chk("acc17_ovf", ovf, 1);
    clr_flags = 1; idle(); clr_flags = 0;
    chk("ovf_cleared", {ovf, s_ovf}, 0);

    idle();
    chk("pre_bp_valid", out_valid, 0);
    out_ready = 0;
    do_op(2'd0, 10'd2, 10'd3);
    chk("bp_first_result", result, 5);
    in_valid = 1; mode = 2'd0; a = 10'd7; b = 10'd8;
    for (int i = 0; i < 3; i++) begin
      idle();
      chk("bp_hold_result", result, 5);
      chk("bp_in_ready", in_ready, 0);
      chk("bp_valid", out_valid, 1);
    end
    chk("bp_acc_hold", acc, 985);
    out_ready = 1; #1;
    chk("bp_in_ready_up", in_ready, 1);
    idle();
    in_valid = 0;
    chk("bp_second_result", result, 15);
    chk("bp_second_valid", out_valid, 1);
    idle();
    chk("bp_drained", out_valid, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
